// File: rtl/adc_spi_sampler_pkg.sv
// Shared types and default widths for the ADC SPI sampler and the filter it feeds.
package adc_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} adc_state_t;

  localparam int ADC_DATA_BITS  = 12;
  localparam int ADC_FRAME_BITS = 16;

endpackage

// File: rtl/adc_spi_sampler_tick.sv
// Sample-rate tick generator: free-running period counter, held at 0 while disabled.
module sample_tick_gen
  import adc_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 100,
  parameter int PERIOD_BITS   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  output logic o_tick
);

  localparam logic [PERIOD_BITS-1:0] COUNT_LAST = PERIOD_BITS'(SAMPLE_PERIOD - 1);

  logic [PERIOD_BITS-1:0] r_count;

  // Period counter; dropping enable restarts the period from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_enable) begin
      r_count <= '0;
    end else if (r_count == COUNT_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = i_enable && (r_count == COUNT_LAST);

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic SPI master for a 12-bit serial ADC (CPOL=1, CS_n framed, MSB first).
// One frame per sample tick; the result is presented with a one-cycle strobe.
module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int DATA_BITS     = ADC_DATA_BITS,
  parameter int FRAME_BITS    = ADC_FRAME_BITS,
  parameter int HALF_DIV      = 2,
  parameter int SAMPLE_PERIOD = 100,
  parameter int PERIOD_BITS   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 adc_sdo,
  output logic                 adc_sclk,
  output logic                 adc_cs_n,
  output logic                 data_out_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 overrun
);

  localparam int HC_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int BC_W = $clog2(FRAME_BITS + 1);
  localparam logic [HC_W-1:0] HALF_LAST = HC_W'(HALF_DIV - 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(FRAME_BITS);

  adc_state_t           r_state;
  logic                 r_cs_n;
  logic                 r_sclk;
  logic                 r_ready;
  logic                 r_overrun;
  logic [HC_W-1:0]      r_half_cnt;
  logic [BC_W-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 w_tick;
  logic                 w_half_done;

  sample_tick_gen #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .PERIOD_BITS  (PERIOD_BITS)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_enable(enable),
    .o_tick  (w_tick)
  );

  assign w_half_done = (r_half_cnt == HALF_LAST);

  // Frame sequencer: CS_n framing, SCLK phases, sampling on SCLK rise, result strobe.
  // The shift register only keeps DATA_BITS; the leading frame bits fall off the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b1;
      r_ready    <= 1'b0;
      r_overrun  <= 1'b0;
      r_half_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
    end else begin
      r_ready   <= 1'b0;
      r_overrun <= w_tick && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          r_cs_n     <= 1'b1;
          r_sclk     <= 1'b1;
          r_half_cnt <= '0;
          r_bit_cnt  <= '0;
          if (w_tick) begin
            r_cs_n  <= 1'b0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (w_half_done) begin
            r_half_cnt <= '0;
            r_sclk     <= 1'b0;
            r_state    <= SHIFT;
          end else begin
            r_half_cnt <= r_half_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!w_half_done) begin
            r_half_cnt <= r_half_cnt + 1'b1;
          end else if (!r_sclk) begin
            r_half_cnt <= '0;
            r_sclk     <= 1'b1;
            r_shift    <= {r_shift[DATA_BITS-2:0], adc_sdo};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
          end else if (r_bit_cnt == BIT_LAST) begin
            r_half_cnt <= '0;
            r_cs_n     <= 1'b1;
            r_ready    <= 1'b1;
            r_data     <= r_shift;
            r_state    <= QUIET;
          end else begin
            r_half_cnt <= '0;
            r_sclk     <= 1'b0;
          end
        end
        QUIET: begin
          if (w_half_done) begin
            r_half_cnt <= '0;
            r_state    <= IDLE;
          end else begin
            r_half_cnt <= r_half_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b1;
        end
      endcase
    end
  end

  assign adc_sclk       = r_sclk;
  assign adc_cs_n       = r_cs_n;
  assign data_out_ready = r_ready;
  assign data_out       = r_data;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Self-checking bench: three sampler instances (defaults, short period, HALF_DIV=1),
// each fed by a behavioural ADC that shifts out a 16-bit word MSB first.
module tb_adc_spi_sampler;

  typedef struct {
    logic [15:0] word;
    logic [11:0] exp;
  } vec_t;

  localparam int LAT_DEF = 1 + 2 * (2 * 16 + 1);
  localparam int LAT_HD1 = 1 + 1 * (2 * 16 + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  en  = 3'b000;
  logic [2:0]  sdo;
  logic [2:0]  sclk;
  logic [2:0]  cs_n;
  logic [2:0]  rdy;
  logic [2:0]  ovr;
  logic [11:0] dout [3];
  logic [15:0] words [3];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_adc
    logic        sdo_bit = 1'b0;
    logic        prev_sclk = 1'b1;
    logic        prev_cs = 1'b1;
    logic        prev_rdy = 1'b0;
    logic        prev_ovr = 1'b0;
    logic [15:0] frame_word = 16'h0000;
    int rises = 0, last_rises = 0, rise_gap = 0, last_rise_cyc = 0;
    int ready_cnt = 0, ready_cyc = 0, csfall_cnt = 0, csfall_cyc = 0;
    int ovr_cnt = 0, ovr_cyc = 0, bad_pulse = 0, idle_toggles = 0;

    adc_spi_sampler #(
      .DATA_BITS    (12),
      .FRAME_BITS   (16),
      .HALF_DIV     ((g == 2) ? 1 : 2),
      .SAMPLE_PERIOD((g == 1) ? 50 : 100),
      .PERIOD_BITS  (7)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (en[g]),
      .adc_sdo       (sdo[g]),
      .adc_sclk      (sclk[g]),
      .adc_cs_n      (cs_n[g]),
      .data_out_ready(rdy[g]),
      .data_out      (dout[g]),
      .overrun       (ovr[g])
    );

    assign sdo[g] = sdo_bit;

    // ADC model and bus monitor: new bit on CS_n fall / SCLK fall, counts edges and pulses
    always @(negedge clk) begin
      if (prev_cs && !cs_n[g]) begin
        rises      = 0;
        frame_word = words[g];
        sdo_bit    = frame_word[15];
        csfall_cnt++;
        csfall_cyc = cyc;
      end else if (!cs_n[g] && !prev_sclk && sclk[g]) begin
        rises++;
        rise_gap      = cyc - last_rise_cyc;
        last_rise_cyc = cyc;
      end else if (!cs_n[g] && prev_sclk && !sclk[g] && rises < 16) begin
        sdo_bit = frame_word[15 - rises];
      end
      if (!prev_cs && cs_n[g]) last_rises = rises;
      if (prev_cs && cs_n[g] && (prev_sclk != sclk[g])) idle_toggles++;
      if (rdy[g]) begin
        ready_cnt++;
        ready_cyc = cyc;
        if (prev_rdy || prev_cs || !cs_n[g]) bad_pulse++;
      end
      if (ovr[g]) begin
        ovr_cnt++;
        ovr_cyc = cyc;
        if (prev_ovr) bad_pulse++;
      end
      prev_sclk = sclk[g];
      prev_cs   = cs_n[g];
      prev_rdy  = rdy[g];
      prev_ovr  = ovr[g];
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic wait_rdy(input int g, input int max_cyc, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[g] && n < max_cyc);
    if (!rdy[g]) check({name, " ready timeout"}, 0, 1);
    #1;
  endtask

  task automatic wait_csfall(input int g, input int max_cyc, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cs_n[g] && n < max_cyc);
    if (cs_n[g]) check({name, " cs_n timeout"}, 0, 1);
    #1;
  endtask

  initial begin
    vec_t tbl [5];
    int   en_cyc, prev_ready, rc, cc, n;
    logic [15:0] w;

    tbl[0] = '{16'h0ABC, 12'hABC};
    tbl[1] = '{16'hFFFF, 12'hFFF};
    tbl[2] = '{16'h0000, 12'h000};
    tbl[3] = '{16'hA5A5, 12'h5A5};
    tbl[4] = '{16'h8001, 12'h001};
    for (int i = 0; i < 3; i++) words[i] = 16'h0000;

    // reset values
    repeat (3) @(negedge clk);
    check("reset cs_n", cs_n, 3'b111);
    check("reset sclk", sclk, 3'b111);
    check("reset ready", rdy, 3'b000);
    check("reset overrun", ovr, 3'b000);
    check("reset data_out", dout[0], 12'h000);
    rst = 1'b0;

    // table-driven frames on the default instance
    @(negedge clk);
    words[0] = tbl[0].word;
    en[0]    = 1'b1;
    en_cyc   = cyc;
    prev_ready = 0;
    for (int i = 0; i < 5; i++) begin
      words[0] = tbl[i].word;
      wait_rdy(0, 250, "table");
      check("table data", dout[0], tbl[i].exp);
      check("table sclk rises", g_adc[0].last_rises, 16);
      check("table cs_n to ready", g_adc[0].ready_cyc - g_adc[0].csfall_cyc, LAT_DEF - 1);
      if (i == 0) check("enable to first ready", g_adc[0].ready_cyc - en_cyc, 100 + LAT_DEF - 1);
      else        check("table ready spacing", g_adc[0].ready_cyc - prev_ready, 100);
      prev_ready = g_adc[0].ready_cyc;
    end

    // randomized frames against the word-to-sample rule
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom);
      words[0] = w;
      wait_rdy(0, 250, "random");
      check("random data", dout[0], w % 4096);
      check("random ready spacing", g_adc[0].ready_cyc - prev_ready, 100);
      prev_ready = g_adc[0].ready_cyc;
    end
    check("default overrun count", g_adc[0].ovr_cnt, 0);

    // period shorter than a frame: every other tick is an overrun
    words[1] = 16'($urandom);
    en[1]    = 1'b1;
    en_cyc   = cyc;
    for (int i = 1; i <= 3; i++) begin
      w = words[1];
      wait_rdy(1, 250, "overrun");
      check("overrun frame data", dout[1], w % 4096);
      check("overrun pulse count", g_adc[1].ovr_cnt, i);
      check("overrun tick offset", g_adc[1].ovr_cyc - g_adc[1].csfall_cyc, 50);
      if (i == 1) check("short period first cs_n", g_adc[1].csfall_cyc - en_cyc, 50);
      words[1] = 16'($urandom);
    end
    en[1] = 1'b0;

    // enable dropped mid-frame, then re-enabled
    words[0] = 16'h7E81;
    wait_csfall(0, 200, "drop");
    repeat (10) @(negedge clk);
    en[0] = 1'b0;
    wait_rdy(0, 100, "drop");
    check("drop frame data", dout[0], 12'hE81);
    rc = g_adc[0].ready_cnt;
    cc = g_adc[0].csfall_cnt;
    repeat (300) @(negedge clk);
    check("disabled no cs_n", g_adc[0].csfall_cnt, cc);
    check("disabled no ready", g_adc[0].ready_cnt, rc);
    words[0] = 16'h0123;
    en[0]    = 1'b1;
    en_cyc   = cyc;
    wait_csfall(0, 200, "reenable");
    check("reenable cs_n delay", g_adc[0].csfall_cyc - en_cyc, 100);

    // reset during bit 8 of the frame just started
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(g_adc[0].rises == 7 && !sclk[0]) && n < 100);
    check("reached bit 8", g_adc[0].rises, 7);
    rc  = g_adc[0].ready_cnt;
    rst = 1'b1;
    #1;
    check("midreset cs_n", cs_n[0], 1'b1);
    check("midreset sclk", sclk[0], 1'b1);
    check("midreset data_out", dout[0], 12'h000);
    repeat (3) @(negedge clk);
    check("midreset no strobe", g_adc[0].ready_cnt, rc);
    rst    = 1'b0;
    en_cyc = cyc;
    wait_rdy(0, 250, "postreset");
    check("postreset data", dout[0], 12'h123);
    check("postreset rises", g_adc[0].last_rises, 16);
    check("postreset first ready", g_adc[0].ready_cyc - en_cyc, 100 + LAT_DEF - 1);
    check("postreset strobe count", g_adc[0].ready_cnt, rc + 1);
    en[0] = 1'b0;

    // HALF_DIV = 1
    words[2] = 16'h0555;
    en[2]    = 1'b1;
    en_cyc   = cyc;
    wait_rdy(2, 250, "hd1");
    check("hd1 data", dout[2], 12'h555);
    check("hd1 cs_n to ready", g_adc[2].ready_cyc - g_adc[2].csfall_cyc, LAT_HD1 - 1);
    check("hd1 sclk period", g_adc[2].rise_gap, 2);
    check("hd1 sclk rises", g_adc[2].last_rises, 16);
    check("hd1 first cs_n", g_adc[2].csfall_cyc - en_cyc, 100);
    prev_ready = g_adc[2].ready_cyc;
    w = 16'($urandom);
    words[2] = w;
    wait_rdy(2, 250, "hd1 random");
    check("hd1 random data", dout[2], w % 4096);
    check("hd1 ready spacing", g_adc[2].ready_cyc - prev_ready, 100);
    en[2] = 1'b0;
    repeat (50) @(negedge clk);

    check("inst0 sclk idle toggles", g_adc[0].idle_toggles, 0);
    check("inst1 sclk idle toggles", g_adc[1].idle_toggles, 0);
    check("inst2 sclk idle toggles", g_adc[2].idle_toggles, 0);
    check("inst0 pulse shape", g_adc[0].bad_pulse, 0);
    check("inst1 pulse shape", g_adc[1].bad_pulse, 0);
    check("inst2 pulse shape", g_adc[2].bad_pulse, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
